uart_tx: RTL and testbench

UART transmitter for the system's serial link, the transmit-side counterpart of the UART receive path. It accepts a parallel word with a single-cycle valid strobe, then serialises one frame: start bit, data LSB-first, optional even/odd parity, and one stop bit. It runs on the TX bit clock, so one clock cycle is one bit period. The frame format matches what the UART receiver and its parity checker expect.

---
 rtl/uart_tx_if.sv | 29 ++
 rtl/uart_tx.sv | 82 ++++++++
 tb/tb_uart_tx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Parallel-side request bundle and serial-side status for the UART transmitter.
interface uart_tx_if #(
  parameter int Data_width = 8
);
  logic [Data_width-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART frame serialiser (start, data LSB-first, optional parity, stop); start bit on the cycle after acceptance.
// No queuing: requests seen while busy are dropped, at least one idle-high cycle separates frames.
module uart_tx #(
  parameter int Data_width = 8
) (
  input  logic       CLK,
  input  logic       RST,
  uart_tx_if.slave   bus
);
  localparam int CW = $clog2(Data_width);
  localparam logic [CW-1:0] LAST = CW'(Data_width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [Data_width-1:0] data_reg;
  logic                  par_en_reg;
  logic                  par_typ_reg;
  logic                  par_bit;
  logic                  accept;
  logic                  tx_nxt, busy_nxt;
  logic                  tx_out_r, busy_r;

  assign accept  = (state == IDLE) && bus.Data_Valid;
  assign par_bit = par_typ_reg ? ~^data_reg : ^data_reg;

  // Outputs decode the next state so the registered line tracks the active state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b1;
    case (state)
      IDLE:   if (bus.Data_Valid) state_nxt = START;
      START: begin
        cnt_nxt   = '0;
        state_nxt = DATA;
      end
      DATA: begin
        if (cnt == LAST) state_nxt = par_en_reg ? PARITY : STOP;
        else             cnt_nxt   = cnt + CW'(1);
      end
      PARITY: state_nxt = STOP;
      STOP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      IDLE:    busy_nxt = 1'b0;
      START:   tx_nxt   = 1'b0;
      DATA:    tx_nxt   = data_reg[cnt_nxt];
      PARITY:  tx_nxt   = par_bit;
      default: tx_nxt   = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      cnt         <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      tx_out_r    <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tx_out_r <= tx_nxt;
      busy_r   <= busy_nxt;
      if (accept) begin
        data_reg    <= bus.P_DATA;
        par_en_reg  <= bus.PAR_EN;
        par_typ_reg <= bus.PAR_TYP;
      end
    end
  end

  assign bus.TX_OUT = tx_out_r;
  assign bus.busy   = busy_r;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: inputs driven and outputs sampled on the falling edge.
module tb_uart_tx;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  uart_tx_if #(.Data_width(8)) bus ();

  uart_tx #(.Data_width(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  // seq is written in time order, first bit in the MSB of the len-bit field.
  task automatic expect_frame(input string tag, input logic [15:0] seq, input int len);
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s_bit%0d", tag, i), {30'd0, bus.busy, bus.TX_OUT}, {30'd0, 1'b1, seq[len-1-i]});
      @(negedge clk);
    end
    check($sformatf("%s_idle", tag), {30'd0, bus.busy, bus.TX_OUT}, 32'd1);
  endtask

  task automatic send(input logic [7:0] data, input logic pe, input logic pt);
    bus.P_DATA     = data;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    bus.Data_Valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    // Reset held with random inputs
    repeat (3) begin
      bus.P_DATA     = 8'($urandom);
      bus.Data_Valid = 1'($urandom_range(0, 1));
      bus.PAR_EN     = 1'($urandom_range(0, 1));
      bus.PAR_TYP    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_hold", {30'd0, bus.busy, bus.TX_OUT}, 32'd1);
    end
    rst            = 1'b1;
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = 'x;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_idle", {30'd0, bus.busy, bus.TX_OUT}, 32'd1);
    end

    // Even and odd parity on 0xA5
    send(8'hA5, 1'b1, 1'b0);
    expect_frame("even_a5", 16'b01010010101, 11);
    send(8'hA5, 1'b1, 1'b1);
    expect_frame("odd_a5", 16'b01010010111, 11);

    // No parity; a request during the frame must be dropped
    send(8'h3C, 1'b0, 1'b0);
    fork
      expect_frame("nopar_3c", 16'b0001111001, 10);
      begin
        repeat (4) @(negedge clk);
        bus.P_DATA     = 8'hFF;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
      end
    join
    repeat (4) begin
      @(negedge clk);
      check("busy_req_dropped", {30'd0, bus.busy, bus.TX_OUT}, 32'd1);
    end

    // Inputs changed mid-frame, then Data_Valid held high for back-to-back frames
    bus.P_DATA     = 8'h5A;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    fork
      expect_frame("stable_5a", 16'b00101101001, 11);
      begin
        repeat (2) @(negedge clk);
        bus.P_DATA  = 8'h01;
        bus.PAR_TYP = 1'b1;
      end
    join
    @(negedge clk);
    expect_frame("b2b_01_a", 16'b01000000001, 11);
    @(negedge clk);
    expect_frame("b2b_01_b", 16'b01000000001, 11);
    bus.Data_Valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("b2b_stop", {30'd0, bus.busy, bus.TX_OUT}, 32'd1);
    end

    // Reset during the 4th data bit of 0xC3 (bit3 = 0)
    send(8'hC3, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_abort_bit3", {30'd0, bus.busy, bus.TX_OUT}, 32'd2);
    rst = 1'b0;
    @(negedge clk);
    check("abort_line_high", {30'd0, bus.busy, bus.TX_OUT}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_stays_idle", {30'd0, bus.busy, bus.TX_OUT}, 32'd1);
    send(8'h96, 1'b1, 1'b1);
    expect_frame("after_abort_96", 16'b00110100111, 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
